// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: turns one local command into an AW/W/B or AR/R
// transaction, returns one response, and aborts through a watchdog if the slave stalls.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | ready for a command (cmd_ready = 1)
// WR     | AW and W issued, waiting for both handshakes
// WR_B   | B_READY high, waiting for the write response
// RD_A   | AR issued, waiting for AR_READY
// RD_R   | R_READY high, waiting for read data
// RSP    | rsp_valid high until the requester takes it
module axi4lite_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      A_CLK,
    input  logic                      A_RSTn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      AW_VALID,
    input  logic                      AW_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
    output logic                      W_VALID,
    input  logic                      W_READY,
    output logic [AXI_DATA_WIDTH-1:0] W_DATA,
    input  logic                      B_VALID,
    output logic                      B_READY,
    input  logic [1:0]                B_RESP,
    output logic                      AR_VALID,
    input  logic                      AR_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    input  logic                      R_VALID,
    output logic                      R_READY,
    input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
    input  logic [1:0]                R_RESP
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RSP} state_t;

    // Counter saturates, so a handshake that wins on the last cycle leaves no fresh budget.
    localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t                    r_state, w_state_nxt;
    logic                      r_aw_valid, r_w_valid, r_b_ready, r_ar_valid, r_r_ready, r_rsp_valid;
    logic                      r_rsp_timeout, r_aw_done, r_w_done;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr, r_ar_addr;
    logic [AXI_DATA_WIDTH-1:0] r_w_data, r_rsp_rdata;
    logic [1:0]                r_rsp_resp;
    logic [WD_W-1:0]           r_wdog;

    logic                      w_aw_valid, w_w_valid, w_b_ready, w_ar_valid, w_r_ready, w_rsp_valid;
    logic                      w_rsp_timeout, w_aw_done_nxt, w_w_done_nxt;
    logic [AXI_ADDR_WIDTH-1:0] w_aw_addr, w_ar_addr;
    logic [AXI_DATA_WIDTH-1:0] w_w_data, w_rsp_rdata;
    logic [1:0]                w_rsp_resp;
    logic [WD_W-1:0]           w_wdog;

    logic w_accept, w_busy, w_aw_done, w_w_done, w_step_done, w_expire, w_abort;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_busy    = (r_state == S_WR) || (r_state == S_WR_B) ||
                       (r_state == S_RD_A) || (r_state == S_RD_R);
    assign w_aw_done = r_aw_done || (r_aw_valid && AW_READY);
    assign w_w_done  = r_w_done  || (r_w_valid && W_READY);
    assign w_expire  = WD_EN && w_busy && (r_wdog >= WD_LAST);
    assign w_abort   = w_expire && !w_step_done;

    always_comb begin
        case (r_state)
            S_WR:    w_step_done = w_aw_done && w_w_done;
            S_WR_B:  w_step_done = B_VALID && r_b_ready;
            S_RD_A:  w_step_done = r_ar_valid && AR_READY;
            S_RD_R:  w_step_done = R_VALID && r_r_ready;
            default: w_step_done = 1'b0;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            r_state       <= S_IDLE;
            r_aw_valid    <= 1'b0;
            r_w_valid     <= 1'b0;
            r_b_ready     <= 1'b0;
            r_ar_valid    <= 1'b0;
            r_r_ready     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_aw_addr     <= '0;
            r_ar_addr     <= '0;
            r_w_data      <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_wdog        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_aw_valid    <= w_aw_valid;
            r_w_valid     <= w_w_valid;
            r_b_ready     <= w_b_ready;
            r_ar_valid    <= w_ar_valid;
            r_r_ready     <= w_r_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_timeout <= w_rsp_timeout;
            r_aw_done     <= w_aw_done_nxt;
            r_w_done      <= w_w_done_nxt;
            r_aw_addr     <= w_aw_addr;
            r_ar_addr     <= w_ar_addr;
            r_w_data      <= w_w_data;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_resp    <= w_rsp_resp;
            r_wdog        <= w_wdog;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = cmd_write ? S_WR : S_RD_A;
            S_WR:   if (w_abort) w_state_nxt = S_RSP; else if (w_step_done) w_state_nxt = S_WR_B;
            S_WR_B: if (w_abort || w_step_done) w_state_nxt = S_RSP;
            S_RD_A: if (w_abort) w_state_nxt = S_RSP; else if (w_step_done) w_state_nxt = S_RD_R;
            S_RD_R: if (w_abort || w_step_done) w_state_nxt = S_RSP;
            S_RSP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_aw_valid    = r_aw_valid;
        w_w_valid     = r_w_valid;
        w_b_ready     = r_b_ready;
        w_ar_valid    = r_ar_valid;
        w_r_ready     = r_r_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_timeout = r_rsp_timeout;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_aw_addr     = r_aw_addr;
        w_ar_addr     = r_ar_addr;
        w_w_data      = r_w_data;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_resp    = r_rsp_resp;
        w_wdog        = (w_busy && r_wdog != '1) ? r_wdog + 1'b1 : r_wdog;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_wdog        = '0;
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
                if (cmd_write) begin
                    w_aw_valid = 1'b1;
                    w_w_valid  = 1'b1;
                    w_aw_addr  = cmd_addr;
                    w_w_data   = cmd_wdata;
                end else begin
                    w_ar_valid = 1'b1;
                    w_ar_addr  = cmd_addr;
                end
            end
            S_WR: begin
                w_aw_done_nxt = w_aw_done;
                w_w_done_nxt  = w_w_done;
                if (w_aw_done) w_aw_valid = 1'b0;
                if (w_w_done)  w_w_valid  = 1'b0;
                if (w_step_done) w_b_ready = 1'b1;
            end
            S_WR_B: if (w_step_done) begin
                w_b_ready     = 1'b0;
                w_rsp_resp    = B_RESP;
                w_rsp_rdata   = '0;
                w_rsp_timeout = 1'b0;
                w_rsp_valid   = 1'b1;
            end
            S_RD_A: if (w_step_done) begin
                w_ar_valid = 1'b0;
                w_r_ready  = 1'b1;
            end
            S_RD_R: if (w_step_done) begin
                w_r_ready     = 1'b0;
                w_rsp_resp    = R_RESP;
                w_rsp_rdata   = R_DATA;
                w_rsp_timeout = 1'b0;
                w_rsp_valid   = 1'b1;
            end
            S_RSP: if (rsp_ready) begin
                w_rsp_valid   = 1'b0;
                w_rsp_timeout = 1'b0;
            end
            default: ;
        endcase
        // Recovery path: drops VALIDs without a handshake so the requester is never hung.
        if (w_abort) begin
            w_aw_valid    = 1'b0;
            w_w_valid     = 1'b0;
            w_b_ready     = 1'b0;
            w_ar_valid    = 1'b0;
            w_r_ready     = 1'b0;
            w_rsp_valid   = 1'b1;
            w_rsp_resp    = 2'b10;
            w_rsp_rdata   = '0;
            w_rsp_timeout = 1'b1;
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;
    assign AW_VALID    = r_aw_valid;
    assign AW_ADDR     = r_aw_addr;
    assign W_VALID     = r_w_valid;
    assign W_DATA      = r_w_data;
    assign B_READY     = r_b_ready;
    assign AR_VALID    = r_ar_valid;
    assign AR_ADDR     = r_ar_addr;
    assign R_READY     = r_r_ready;

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: configurable AXI-Lite slave model plus a
// response scoreboard filled at command time and drained when rsp_valid appears.
module tb_axi4lite_master;

    logic        A_CLK = 1'b0;
    logic        A_RSTn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [31:0] AW_ADDR, W_DATA, AR_ADDR, R_DATA;
    logic [1:0]  B_RESP, R_RESP;

    axi4lite_master #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .A_CLK(A_CLK), .A_RSTn(A_RSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
    );

    always #5 A_CLK = ~A_CLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // slave configuration, written by the main sequence
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] mem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: all decisions at negedge; VALID&&READY seen here completes at the next posedge.
    initial begin : slave
        logic aw_got, w_got, ar_got, b_pend, r_pend;
        int aw_cnt, w_cnt, ar_cnt, r_cnt;
        logic [31:0] aw_q, w_q, ar_q;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
        AR_READY = 0; R_VALID = 0; R_DATA = 0; R_RESP = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_q = 0; w_q = 0; ar_q = 0;
        forever begin
            @(negedge A_CLK);
            if (!A_RSTn || cmd_ready) begin
                AW_READY = 0; W_READY = 0; B_VALID = 0; AR_READY = 0; R_VALID = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (b_pend) begin
                    B_VALID = 0; b_pend = 0; aw_got = 0; w_got = 0;
                end else begin
                    if (!B_VALID && aw_got && w_got) begin
                        B_VALID = 1; B_RESP = b_resp_cfg; mem[aw_q[5:2]] = w_q;
                    end
                    if (B_VALID && B_READY) b_pend = 1;
                end
                AW_READY = 0;
                if (AW_VALID && !aw_got) begin
                    if (aw_cnt >= aw_lat) begin AW_READY = 1; aw_got = 1; aw_q = AW_ADDR; end
                    else aw_cnt++;
                end else aw_cnt = 0;
                W_READY = 0;
                if (W_VALID && !w_got) begin
                    if (w_cnt >= w_lat) begin W_READY = 1; w_got = 1; w_q = W_DATA; end
                    else w_cnt++;
                end else w_cnt = 0;
                if (r_pend) begin
                    R_VALID = 0; r_pend = 0; ar_got = 0; r_cnt = 0;
                end else if (ar_got) begin
                    if (!R_VALID) begin
                        if (r_cnt >= r_lat) begin
                            R_VALID = 1; R_DATA = mem[ar_q[5:2]]; R_RESP = r_resp_cfg;
                        end else r_cnt++;
                    end
                    if (R_VALID && R_READY) r_pend = 1;
                end
                AR_READY = 0;
                if (AR_VALID && !ar_got) begin
                    if (ar_lat >= 0 && ar_cnt >= ar_lat) begin AR_READY = 1; ar_got = 1; ar_q = AR_ADDR; end
                    else ar_cnt++;
                end else ar_cnt = 0;
            end
        end
    end

    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] e_data, input logic [1:0] e_resp, input logic e_to);
        int n;
        exp_t e;
        @(negedge A_CLK);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 60) begin @(negedge A_CLK); n++; end
        chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
        e.data = e_data; e.resp = e_resp; e.to = e_to;
        sb.push_back(e);
        @(posedge A_CLK);
        #1 cmd_valid = 0;
    endtask

    task automatic get_rsp(input int hold);
        int n;
        exp_t e;
        @(negedge A_CLK);
        n = 0;
        while (!rsp_valid && n < 60) begin @(negedge A_CLK); n++; end
        chk("rsp_valid_wait", {31'b0, rsp_valid}, 32'd1);
        chk("sb_nonempty", {31'b0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.data);
            chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
            chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
            chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge A_CLK);
                chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
                chk("hold_rdata", rsp_rdata, e.data);
                chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            end
        end
        rsp_ready = 1;
        @(negedge A_CLK);
        rsp_ready = 0;
        chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("rsp_to_clear", {31'b0, rsp_timeout}, 32'd0);
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin : main
        int cnt;
        int bad;
        A_RSTn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        repeat (3) @(negedge A_CLK);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_aw_valid", {31'b0, AW_VALID}, 32'd0);
        chk("rst_w_valid", {31'b0, W_VALID}, 32'd0);
        chk("rst_ar_valid", {31'b0, AR_VALID}, 32'd0);
        chk("rst_b_ready", {31'b0, B_READY}, 32'd0);
        chk("rst_r_ready", {31'b0, R_READY}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_resp", {30'b0, rsp_resp}, 32'd0);
        chk("rst_aw_addr", AW_ADDR, 32'd0);
        A_RSTn = 1;

        // zero-wait write
        do_cmd(1'b1, 32'h04, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);
        @(negedge A_CLK);
        chk("wr_aw_valid_lat", {31'b0, AW_VALID}, 32'd1);
        chk("wr_w_valid_lat", {31'b0, W_VALID}, 32'd1);
        chk("wr_aw_addr", AW_ADDR, 32'h04);
        chk("wr_w_data", W_DATA, 32'hDEADBEEF);
        get_rsp(0);

        // read-back
        do_cmd(1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0);
        @(negedge A_CLK);
        chk("rd_ar_valid_lat", {31'b0, AR_VALID}, 32'd1);
        chk("rd_ar_addr", AR_ADDR, 32'h04);
        get_rsp(0);

        // skewed write, SLVERR on B
        w_lat = 5; b_resp_cfg = 2'b10;
        do_cmd(1'b1, 32'h0C, 32'hA5A55A5A, 32'h0, 2'b10, 1'b0);
        @(negedge A_CLK);
        chk("skew_aw_valid_c1", {31'b0, AW_VALID}, 32'd1);
        @(negedge A_CLK);
        chk("skew_aw_valid_c2", {31'b0, AW_VALID}, 32'd0);
        bad = 0; cnt = 0;
        while (W_VALID && cnt < 30) begin
            if (W_DATA !== 32'hA5A55A5A || B_READY !== 1'b0) bad++;
            @(negedge A_CLK);
            cnt++;
        end
        chk("skew_w_stable", bad, 32'd0);
        chk("skew_w_cycles", cnt, 32'd5);
        chk("skew_b_ready", {31'b0, B_READY}, 32'd1);
        get_rsp(0);
        w_lat = 0; b_resp_cfg = 2'b00;

        // read with R stall and SLVERR, requester holds off 4 cycles
        r_lat = 3; r_resp_cfg = 2'b10;
        do_cmd(1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 2'b10, 1'b0);
        get_rsp(4);
        r_lat = 0; r_resp_cfg = 2'b00;

        // slave never accepts AR: watchdog abort after 8 cycles
        ar_lat = -1;
        do_cmd(1'b0, 32'h04, 32'h0, 32'h0, 2'b10, 1'b1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge A_CLK);
            if (rsp_valid) break;
            if (AR_VALID) cnt++;
        end
        chk("to_ar_cycles", cnt, 32'd8);
        chk("to_ar_dropped", {31'b0, AR_VALID}, 32'd0);
        get_rsp(0);
        ar_lat = 0;
        do_cmd(1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0);
        get_rsp(0);

        // reset in the middle of a write with W pending
        w_lat = 20;
        do_cmd(1'b1, 32'h10, 32'h12345678, 32'h0, 2'b00, 1'b0);
        repeat (3) @(negedge A_CLK);
        chk("mid_w_pending", {31'b0, W_VALID}, 32'd1);
        A_RSTn = 0;
        @(negedge A_CLK);
        chk("mr_aw_valid", {31'b0, AW_VALID}, 32'd0);
        chk("mr_w_valid", {31'b0, W_VALID}, 32'd0);
        chk("mr_b_ready", {31'b0, B_READY}, 32'd0);
        chk("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        sb.delete();
        A_RSTn = 1;
        w_lat = 0;
        do_cmd(1'b1, 32'h08, 32'hCAFEF00D, 32'h0, 2'b00, 1'b0);
        get_rsp(0);
        do_cmd(1'b0, 32'h08, 32'h0, 32'hCAFEF00D, 2'b00, 1'b0);
        get_rsp(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
